// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, requester IDs and types for the sprite ROM arbiter
package sprite_pkg;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 4;
   localparam int ROM_LAT = 1;
   typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
   typedef logic [DATA_W-1:0] pal_idx_t;
   localparam req_id_t REQ_PLAYER = 0;
   localparam req_id_t REQ_ENEMY0 = 1;
   localparam req_id_t REQ_ENEMY1 = 2;
   localparam req_id_t REQ_BULLET = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker scanning req upward from base with wrap
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] base,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] k,
   output logic                       any
);
   localparam int IDW = $clog2(NUM_REQ);
   int j;
   // Scan from farthest to nearest so the nearest set bit from base wins
   always_comb begin
      gnt = '0;
      k   = '0;
      any = 1'b0;
      j   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = (int'(base) + i) % NUM_REQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            k      = IDW'(j);
            any    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM port with an ID-tagged response path
module sprite_rom_arbiter #(
   parameter int NUM_REQ = sprite_pkg::NUM_REQ,
   parameter int ADDR_W  = sprite_pkg::ADDR_W,
   parameter int DATA_W  = sprite_pkg::DATA_W,
   parameter int ROM_LAT = sprite_pkg::ROM_LAT
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         FrameStart,
   input  logic [NUM_REQ-1:0]           Req,
   input  logic [NUM_REQ*ADDR_W-1:0]    ReqAddr,
   output logic [NUM_REQ-1:0]           Gnt,
   output logic                         RomRdEn,
   output logic [ADDR_W-1:0]            RomAddr,
   input  logic [DATA_W-1:0]            RomData,
   output logic                         RspValid,
   output logic [$clog2(NUM_REQ)-1:0]   RspId,
   output logic [DATA_W-1:0]            RspData
);
   import sprite_pkg::*;
   localparam int IDW = $clog2(NUM_REQ);
   logic [IDW-1:0]            ptr_q, ptr_d, base, k;
   logic [NUM_REQ-1:0]        pick_gnt;
   logic                      pick_any, any;
   logic                      rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [ROM_LAT:0]          tv_q, tv_d;
   logic [ROM_LAT:0][IDW-1:0] tid_q, tid_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]            rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]         rsp_data_q, rsp_data_d;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req  (Req),
      .base (base),
      .gnt  (pick_gnt),
      .k    (k),
      .any  (pick_any)
   );

   // Grant, pointer update, issue stage and tag shift; grants are suppressed while in reset
   always_comb begin
      base        = FrameStart ? '0 : ptr_q;
      any         = pick_any & Reset_n;
      Gnt         = Reset_n ? pick_gnt : '0;
      ptr_d       = any ? ((k == IDW'(NUM_REQ - 1)) ? '0 : k + IDW'(1)) : base;
      rd_en_d     = any;
      addr_d      = any ? ReqAddr[k*ADDR_W +: ADDR_W] : addr_q;
      tv_d        = {tv_q[ROM_LAT-1:0], any};
      tid_d       = {tid_q[ROM_LAT-1:0], k};
      rsp_valid_d = tv_q[ROM_LAT];
      rsp_id_d    = tv_q[ROM_LAT] ? tid_q[ROM_LAT] : rsp_id_q;
      rsp_data_d  = tv_q[ROM_LAT] ? RomData : rsp_data_q;
   end

   // State registers; async reset drops every in-flight request
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q       <= '0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         tv_q        <= '0;
         tid_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         tv_q        <= tv_d;
         tid_q       <= tid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign RomRdEn  = rd_en_q;
   assign RomAddr  = addr_q;
   assign RspValid = rsp_valid_q;
   assign RspId    = rsp_id_q;
   assign RspData  = rsp_data_q;

   a_addr_known: assert property (@(posedge Clk) disable iff (!Reset_n)
      any |-> !$isunknown(ReqAddr[k*ADDR_W +: ADDR_W]));
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: scoreboard bench for the sprite ROM arbiter
module tb_sprite_rom_arbiter;
   import sprite_pkg::*;
   localparam int LAT = 1;
   localparam int IDW = $clog2(NUM_REQ);

   logic                      Clk = 1'b0;
   logic                      Reset_n, FrameStart;
   logic [NUM_REQ-1:0]        Req, Gnt;
   logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
   logic                      RomRdEn, RspValid;
   logic [ADDR_W-1:0]         RomAddr;
   logic [DATA_W-1:0]         RomData, RspData;
   logic [IDW-1:0]            RspId;

   typedef struct {
      int             id;
      logic [DATA_W-1:0] data;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .FrameStart(FrameStart), .Req(Req), .ReqAddr(ReqAddr),
      .Gnt(Gnt), .RomRdEn(RomRdEn), .RomAddr(RomAddr), .RomData(RomData),
      .RspValid(RspValid), .RspId(RspId), .RspData(RspData)
   );

   function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8];
   endfunction

   // Synchronous ROM model with LAT cycles of read latency
   logic [DATA_W-1:0] rom_pipe [LAT];
   always @(posedge Clk) begin
      rom_pipe[0] <= rom_f(RomAddr);
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign RomData = rom_pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   // Reference arbiter + scoreboard: predicts grants and issue, pushes expected responses
   int mptr = 0;
   int mbase, ek;
   bit found, prev_found;
   logic [ADDR_W-1:0] last_addr = '0;
   exp_t e;
   always @(negedge Clk) begin
      if (!Reset_n) begin
         sb.delete();
         mptr       = 0;
         prev_found = 0;
         last_addr  = '0;
      end else begin
         if (RspValid) begin
            if (sb.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               check("rsp_id", 32'(RspId), e.id);
               check("rsp_data", 32'(RspData), 32'(e.data));
            end
         end
         check("issue_en", 32'(RomRdEn), 32'(prev_found));
         check("issue_addr", 32'(RomAddr), 32'(last_addr));
         mbase = FrameStart ? 0 : mptr;
         found = 0;
         ek    = 0;
         for (int i = 0; i < NUM_REQ; i++)
            if (!found && Req[(mbase + i) % NUM_REQ]) begin
               found = 1;
               ek    = (mbase + i) % NUM_REQ;
            end
         check("gnt", 32'(Gnt), found ? (32'd1 << ek) : 32'd0);
         prev_found = found;
         if (found) begin
            last_addr = ReqAddr[ek*ADDR_W +: ADDR_W];
            sb.push_back('{id: ek, data: rom_f(last_addr)});
            mptr = (ek + 1) % NUM_REQ;
         end else if (FrameStart) mptr = 0;
      end
   end

   logic [DATA_W-1:0] b2b_exp [3];

   initial begin
      b2b_exp = '{4'h1, 4'h0, 4'h3};
      Reset_n = 1'b0; FrameStart = 1'b0; Req = '1; ReqAddr = '0;
      repeat (2) @(negedge Clk);
      check("rst_gnt", 32'(Gnt), 0);
      check("rst_rden", 32'(RomRdEn), 0);
      check("rst_rsp", 32'(RspValid), 0);
      cyc();
      Req = '0;
      Reset_n = 1'b1;
      // Single requester
      cyc();
      Req = 4'b0100;
      ReqAddr[2*ADDR_W +: ADDR_W] = 12'h1A3;
      @(negedge Clk);
      check("single_gnt", 32'(Gnt), 32'h4);
      cyc();
      Req = '0;
      @(negedge Clk);
      check("single_rden", 32'(RomRdEn), 1);
      check("single_addr", 32'(RomAddr), 32'h1A3);
      cyc();
      cyc();
      @(negedge Clk);
      check("single_vld", 32'(RspValid), 1);
      check("single_id", 32'(RspId), 32'(REQ_ENEMY1));
      check("single_data", 32'(RspData), 32'h8);
      // Full contention from reset
      cyc();
      Reset_n = 1'b0;
      cyc();
      Reset_n = 1'b1;
      ReqAddr = {12'h345, 12'h236, 12'h127, 12'h018};
      Req = 4'b1111;
      for (int i = 0; i < 11; i++) begin
         if (i == 8) Req = '0;
         @(negedge Clk);
         if (i < 8) check("rr_gnt", 32'(Gnt), 32'd1 << (i % 4));
         if (i >= 3) begin
            check("rr_vld", 32'(RspValid), 1);
            check("rr_id", 32'(RspId), (i - 3) % 4);
         end
         cyc();
      end
      // Pointer wrap and hold across idle
      Req = 4'b1000;
      @(negedge Clk);
      check("wrap_gnt3", 32'(Gnt), 32'h8);
      cyc();
      Req = '0;
      cyc();
      Req = 4'b1001;
      @(negedge Clk);
      check("wrap_gnt0", 32'(Gnt), 32'h1);
      cyc();
      // FrameStart override with Ptr=2
      Req = 4'b0010;
      @(negedge Clk);
      check("fs_setup", 32'(Gnt), 32'h2);
      cyc();
      Req = 4'b0101;
      FrameStart = 1'b1;
      @(negedge Clk);
      check("fs_gnt", 32'(Gnt), 32'h1);
      cyc();
      FrameStart = 1'b0;
      Req = 4'b0100;
      @(negedge Clk);
      check("fs_next", 32'(Gnt), 32'h4);
      cyc();
      Req = '0;
      repeat (4) cyc();
      // Back-to-back from one requester
      Req = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         ReqAddr[1*ADDR_W +: ADDR_W] = 12'h010 + 12'(i);
         @(negedge Clk);
         check("b2b_gnt", 32'(Gnt), 32'h2);
         cyc();
      end
      Req = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("b2b_vld", 32'(RspValid), 1);
         check("b2b_id", 32'(RspId), 32'(REQ_ENEMY0));
         check("b2b_data", 32'(RspData), 32'(b2b_exp[i]));
         cyc();
      end
      // Reset with two responses in flight
      Req = 4'b0001;
      cyc();
      Req = 4'b0010;
      cyc();
      Req = 4'b0100;
      #1 Reset_n = 1'b0;
      #1;
      check("mrst_gnt", 32'(Gnt), 0);
      check("mrst_rden", 32'(RomRdEn), 0);
      check("mrst_addr", 32'(RomAddr), 0);
      check("mrst_vld", 32'(RspValid), 0);
      check("mrst_id", 32'(RspId), 0);
      check("mrst_data", 32'(RspData), 0);
      Req = '0;
      cyc();
      cyc();
      Reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         check("mrst_dropped", 32'(RspValid), 0);
         cyc();
      end
      check("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
